// File: rtl/openram_ctrl_if.sv
// Request/response channels plus OpenRAM macro pins for openram_ctrl.
// slave = controller view; master = initiator and SRAM macro view.
interface openram_ctrl_if #(
  parameter int DataWidth = 32,
  parameter int AddrWidth = 32
);
  logic                 reqValid;
  logic                 reqReady;
  logic [AddrWidth-1:0] reqAddr;
  logic                 reqWrite;
  logic [DataWidth-1:0] reqWData;
  logic                 respValid;
  logic                 respReady;
  logic [DataWidth-1:0] respRData;
  logic                 respErr;
  logic [AddrWidth-1:0] ramAddr;
  logic [DataWidth-1:0] ramDataIn;
  logic [DataWidth-1:0] ramDataOut;
  logic                 ramCS_B;
  logic                 ramWE_B;
  logic                 ramOE_B;

  modport slave (
    input  reqValid, reqAddr, reqWrite, reqWData, respReady, ramDataOut,
    output reqReady, respValid, respRData, respErr,
    output ramAddr, ramDataIn, ramCS_B, ramWE_B, ramOE_B
  );

  modport master (
    output reqValid, reqAddr, reqWrite, reqWData, respReady, ramDataOut,
    input  reqReady, respValid, respRData, respErr,
    input  ramAddr, ramDataIn, ramCS_B, ramWE_B, ramOE_B
  );
endinterface

// File: rtl/openram_ctrl.sv
// Single-transaction sequencer driving the strobes of a single-port OpenRAM macro.
// Define OPENRAM_CTRL_RANGE_CHECK_EN to reject addresses >= Depth with respErr.
//
// state  | meaning
// IDLE   | reqReady high, waiting for a request
// STROBE | one cycle with ramCS_B low (WE_B low for write, OE_B low for read)
// WAIT   | read in flight; ramOE_B held low for ReadLatency cycles
// RESP   | response offered; leave on respValid && respReady
module openram_ctrl #(
  parameter int DataWidth   = 32,
  parameter int AddrWidth   = 32,
  parameter int ReadLatency = 1,
  parameter int Depth       = 256
) (
  input logic           clk,
  input logic           reset,
  openram_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, STROBE, WAIT, RESP} state_e;

  state_e               state_q, state_d;
  logic                 write_q, write_d;
  logic [3:0]           cnt_q, cnt_d;
  logic [AddrWidth-1:0] ram_addr_q, ram_addr_d;
  logic [DataWidth-1:0] ram_din_q, ram_din_d;
  logic                 cs_b_q, cs_b_d;
  logic                 we_b_q, we_b_d;
  logic                 oe_b_q, oe_b_d;
  logic                 resp_valid_q, resp_valid_d;
  logic [DataWidth-1:0] rdata_q, rdata_d;
  logic                 addr_oor;

  if (ReadLatency < 1 || ReadLatency > 15 || Depth < 1) begin : g_bad_param
    $error("openram_ctrl: ReadLatency must be 1-15 and Depth positive");
  end

`ifdef OPENRAM_CTRL_RANGE_CHECK_EN
  localparam logic [AddrWidth:0] DepthLim = (AddrWidth+1)'(Depth);

  logic err_q, err_d;

  assign addr_oor    = ({1'b0, bus.reqAddr} >= DepthLim);
  assign bus.respErr = err_q;
`else
  assign addr_oor    = 1'b0;
  assign bus.respErr = 1'b0;
`endif

  // Strobes are registered from the next state, so they line up with STROBE/WAIT.
  always_comb begin
    state_d      = state_q;
    write_d      = write_q;
    cnt_d        = cnt_q;
    ram_addr_d   = ram_addr_q;
    ram_din_d    = ram_din_q;
    cs_b_d       = 1'b1;
    we_b_d       = 1'b1;
    oe_b_d       = 1'b1;
    resp_valid_d = resp_valid_q;
    rdata_d      = rdata_q;
`ifdef OPENRAM_CTRL_RANGE_CHECK_EN
    err_d        = err_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.reqValid) begin
          write_d = bus.reqWrite;
`ifdef OPENRAM_CTRL_RANGE_CHECK_EN
          err_d   = addr_oor;
`endif
          if (addr_oor) begin
            state_d = RESP;
            rdata_d = '0;
          end else begin
            state_d    = STROBE;
            cs_b_d     = 1'b0;
            ram_addr_d = bus.reqAddr;
            if (bus.reqWrite) begin
              we_b_d    = 1'b0;
              ram_din_d = bus.reqWData;
            end else begin
              oe_b_d = 1'b0;
            end
          end
        end
      end
      STROBE: begin
        if (write_q) begin
          state_d = RESP;
          rdata_d = '0;
        end else begin
          state_d = WAIT;
          cnt_d   = 4'(ReadLatency);
          oe_b_d  = 1'b0;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = RESP;
          rdata_d = bus.ramDataOut;
        end else begin
          oe_b_d = 1'b0;
        end
      end
      RESP: begin
        resp_valid_d = 1'b1;
        if (resp_valid_q && bus.respReady) begin
          resp_valid_d = 1'b0;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      write_q      <= 1'b0;
      cnt_q        <= '0;
      ram_addr_q   <= '0;
      ram_din_q    <= '0;
      cs_b_q       <= 1'b1;
      we_b_q       <= 1'b1;
      oe_b_q       <= 1'b1;
      resp_valid_q <= 1'b0;
      rdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      write_q      <= write_d;
      cnt_q        <= cnt_d;
      ram_addr_q   <= ram_addr_d;
      ram_din_q    <= ram_din_d;
      cs_b_q       <= cs_b_d;
      we_b_q       <= we_b_d;
      oe_b_q       <= oe_b_d;
      resp_valid_q <= resp_valid_d;
      rdata_q      <= rdata_d;
    end
  end

`ifdef OPENRAM_CTRL_RANGE_CHECK_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) err_q <= 1'b0;
    else       err_q <= err_d;
  end
`endif

  assign bus.reqReady  = (state_q == IDLE);
  assign bus.respValid = resp_valid_q;
  assign bus.respRData = rdata_q;
  assign bus.ramAddr   = ram_addr_q;
  assign bus.ramDataIn = ram_din_q;
  assign bus.ramCS_B   = cs_b_q;
  assign bus.ramWE_B   = we_b_q;
  assign bus.ramOE_B   = oe_b_q;

endmodule

// File: tb/tb_openram_ctrl.sv
// Directed bench for openram_ctrl: one instance at ReadLatency=1 and one at 3, each with a macro model.
module tb_openram_ctrl;
  localparam logic [31:0] JUNK = 32'hBAD0_BAD0;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        sel = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_write = 1'b0;
  logic        resp_ready = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  openram_ctrl_if #(.DataWidth(32), .AddrWidth(32)) b1 ();
  openram_ctrl_if #(.DataWidth(32), .AddrWidth(32)) b3 ();

  assign b1.reqValid  = req_valid & ~sel;
  assign b1.respReady = resp_ready & ~sel;
  assign b1.reqAddr   = req_addr;
  assign b1.reqWrite  = req_write;
  assign b1.reqWData  = req_wdata;
  assign b3.reqValid  = req_valid & sel;
  assign b3.respReady = resp_ready & sel;
  assign b3.reqAddr   = req_addr;
  assign b3.reqWrite  = req_write;
  assign b3.reqWData  = req_wdata;

  openram_ctrl #(.DataWidth(32), .AddrWidth(32), .ReadLatency(1), .Depth(256)) u_dut1 (
    .clk(clk), .reset(reset), .bus(b1));
  openram_ctrl #(.DataWidth(32), .AddrWidth(32), .ReadLatency(3), .Depth(256)) u_dut3 (
    .clk(clk), .reset(reset), .bus(b3));

  // Macro models: strobe seen in cycle 0, dataOut valid only during cycle ReadLatency.
  logic [31:0] mem1 [256];
  logic [31:0] mem3 [256];

  initial begin : model1
    logic [7:0] a;
    b1.ramDataOut = JUNK;
    forever begin
      @(negedge clk);
      if (!b1.ramCS_B && !b1.ramWE_B) mem1[b1.ramAddr[7:0]] = b1.ramDataIn;
      else if (!b1.ramCS_B) begin
        a = b1.ramAddr[7:0];
        repeat (1) @(posedge clk);
        #1 b1.ramDataOut = mem1[a];
        @(posedge clk);
        #1 b1.ramDataOut = JUNK;
      end
    end
  end

  initial begin : model3
    logic [7:0] a;
    b3.ramDataOut = JUNK;
    forever begin
      @(negedge clk);
      if (!b3.ramCS_B && !b3.ramWE_B) mem3[b3.ramAddr[7:0]] = b3.ramDataIn;
      else if (!b3.ramCS_B) begin
        a = b3.ramAddr[7:0];
        repeat (3) @(posedge clk);
        #1 b3.ramDataOut = mem3[a];
        @(posedge clk);
        #1 b3.ramDataOut = JUNK;
      end
    end
  end

  logic        o_ready, o_valid, o_err, o_cs, o_we, o_oe;
  logic [31:0] o_rdata, o_addr, o_din;
  assign o_ready = sel ? b3.reqReady  : b1.reqReady;
  assign o_valid = sel ? b3.respValid : b1.respValid;
  assign o_err   = sel ? b3.respErr   : b1.respErr;
  assign o_cs    = sel ? b3.ramCS_B   : b1.ramCS_B;
  assign o_we    = sel ? b3.ramWE_B   : b1.ramWE_B;
  assign o_oe    = sel ? b3.ramOE_B   : b1.ramOE_B;
  assign o_rdata = sel ? b3.respRData : b1.respRData;
  assign o_addr  = sel ? b3.ramAddr   : b1.ramAddr;
  assign o_din   = sel ? b3.ramDataIn : b1.ramDataIn;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic do_txn(input string nm, input logic s, input logic wr,
                        input logic [31:0] addr, input logic [31:0] data, input int hold,
                        input int exp_lat, input logic [31:0] exp_rdata, input logic exp_err,
                        input int exp_cs, input int exp_oe);
    int          k, n_cs, n_we, n_oe, bad_we;
    logic [31:0] seen_addr, seen_din, rd;
    @(negedge clk);
    sel = s;
    #1;
    chk({nm, "_ready_idle"}, 32'(o_ready), 1);
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = addr;
    req_wdata = data;
    @(negedge clk);
    req_valid = 1'b0;
    req_write = ~wr;
    req_addr  = ~addr;
    req_wdata = ~data;
    k = 0; n_cs = 0; n_we = 0; n_oe = 0; bad_we = 0;
    seen_addr = '1; seen_din = '1;
    while (!o_valid && k < 40) begin
      if (!o_cs) begin
        n_cs++;
        seen_addr = o_addr;
        seen_din  = o_din;
      end
      if (!o_we) n_we++;
      if (!o_oe) n_oe++;
      if (!o_we && o_cs) bad_we++;
      @(negedge clk);
      k++;
    end
    chk({nm, "_latency"}, 32'(k), 32'(exp_lat));
    chk({nm, "_cs_cycles"}, 32'(n_cs), 32'(exp_cs));
    chk({nm, "_we_cycles"}, 32'(n_we), wr ? 32'(exp_cs) : 32'd0);
    chk({nm, "_oe_cycles"}, 32'(n_oe), 32'(exp_oe));
    chk({nm, "_we_without_cs"}, 32'(bad_we), 0);
    if (exp_cs > 0) chk({nm, "_ram_addr"}, seen_addr, addr);
    if (wr && exp_cs > 0) chk({nm, "_ram_din"}, seen_din, data);
    rd = o_rdata;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk({nm, "_hold_valid"}, 32'(o_valid), 1);
      chk({nm, "_hold_rdata"}, o_rdata, rd);
      chk({nm, "_hold_ready"}, 32'(o_ready), 0);
    end
    chk({nm, "_rdata"}, o_rdata, exp_rdata);
    chk({nm, "_err"}, 32'(o_err), 32'(exp_err));
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    chk({nm, "_valid_drop"}, 32'(o_valid), 0);
    chk({nm, "_ready_back"}, 32'(o_ready), 1);
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int          accepted, pulses, resps, stale;
    logic [31:0] q[$];
    logic [31:0] exp_a;

    repeat (2) @(negedge clk);
    chk("rst_cs1", 32'(b1.ramCS_B), 1);
    chk("rst_we1", 32'(b1.ramWE_B), 1);
    chk("rst_oe1", 32'(b1.ramOE_B), 1);
    chk("rst_addr1", b1.ramAddr, 0);
    chk("rst_din1", b1.ramDataIn, 0);
    chk("rst_valid1", 32'(b1.respValid), 0);
    chk("rst_rdata1", b1.respRData, 0);
    chk("rst_err1", 32'(b1.respErr), 0);
    chk("rst_ready1", 32'(b1.reqReady), 1);
    chk("rst_cs3", 32'(b3.ramCS_B), 1);
    chk("rst_valid3", 32'(b3.respValid), 0);
    reset = 1'b0;

    // name            sel wr addr        data          hold lat rdata         err cs oe
    do_txn("wr10",      0, 1, 32'h10,  32'hDEADBEEF, 0,   2,  32'h0,        0,  1, 0);
    do_txn("rd10",      0, 0, 32'h10,  32'h0,        4,   3,  32'hDEADBEEF, 0,  1, 2);
    do_txn("wr03",      0, 1, 32'h03,  32'hA5A50F0F, 2,   2,  32'h0,        0,  1, 0);
    do_txn("rd03",      0, 0, 32'h03,  32'h0,        0,   3,  32'hA5A50F0F, 0,  1, 2);
    do_txn("rd10_again",0, 0, 32'h10,  32'h0,        1,   3,  32'hDEADBEEF, 0,  1, 2);
    do_txn("rl3_wr",    1, 1, 32'h10,  32'hCAFEF00D, 0,   2,  32'h0,        0,  1, 0);
    do_txn("rl3_rd",    1, 0, 32'h10,  32'h0,        2,   5,  32'hCAFEF00D, 0,  1, 4);
    do_txn("wr_ff",     0, 1, 32'hFF,  32'h5A5A5A5A, 0,   2,  32'h0,        0,  1, 0);
    do_txn("rd_ff",     0, 0, 32'hFF,  32'h0,        0,   3,  32'h5A5A5A5A, 0,  1, 2);
`ifdef OPENRAM_CTRL_RANGE_CHECK_EN
    do_txn("oor_rd",    0, 0, 32'h100, 32'h0,        2,   1,  32'h0,        1,  0, 0);
    do_txn("oor_wr",    0, 1, 32'h100, 32'h12345678, 0,   1,  32'h0,        1,  0, 0);
`else
    do_txn("hi_wr",     0, 1, 32'h100, 32'h0BAD1000, 0,   2,  32'h0,        0,  1, 0);
    do_txn("hi_rd",     0, 0, 32'h100, 32'h0,        0,   3,  32'h0BAD1000, 0,  1, 2);
`endif

    // Busy: reqValid held high, address changes every cycle, consumer always ready.
    @(negedge clk);
    sel = 1'b0;
    #1;
    resp_ready = 1'b1;
    req_write  = 1'b0;
    accepted = 0; pulses = 0; resps = 0;
    for (int i = 0; i < 40; i++) begin
      req_valid = (i < 30);
      req_addr  = 32'h40 + 32'(i);
      #1;
      if (!o_cs) begin
        pulses++;
        exp_a = (q.size() > 0) ? q.pop_front() : 32'hFFFF_FFFF;
        chk("busy_issued_addr", o_addr, exp_a);
      end
      if (o_valid && resp_ready) resps++;
      if (req_valid && o_ready) begin
        accepted++;
        q.push_back(req_addr);
      end
      @(negedge clk);
    end
    resp_ready = 1'b0;
    req_valid  = 1'b0;
    chk("busy_accepted", 32'(accepted), 6);
    chk("busy_cs_pulses", 32'(pulses), 6);
    chk("busy_responses", 32'(resps), 6);
    chk("busy_queue_empty", 32'(q.size()), 0);

    // Reset while the RL=3 instance sits in WAIT.
    @(negedge clk);
    sel = 1'b1;
    #1;
    req_write = 1'b0;
    req_addr  = 32'h22;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("mid_oe_low", 32'(o_oe), 0);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_cs", 32'(o_cs), 1);
    chk("mid_rst_oe", 32'(o_oe), 1);
    chk("mid_rst_we", 32'(o_we), 1);
    chk("mid_rst_valid", 32'(o_valid), 0);
    @(negedge clk);
    reset = 1'b0;
    stale = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (o_valid || !o_cs) stale++;
    end
    chk("mid_no_stale", 32'(stale), 0);
    chk("mid_ready", 32'(o_ready), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
